writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 16, giving the width of the writeback data.
REQ-002 The block SHALL have the parameter REG_ADDR_WIDTH, default 3, giving the width of the register address.
REQ-003 The block SHALL have the parameter MAX_STREAK, default 3, giving the number of consecutive memory grants allowed while an ALU request waits.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have the port alu_valid, input, 1 bit: an ALU result is pending.
REQ-007 The block SHALL have the port alu_rd, input, REG_ADDR_WIDTH bits: destination register of the ALU result.
REQ-008 The block SHALL have the port alu_data, input, DATA_WIDTH bits: the ALU result.
REQ-009 The block SHALL have the port alu_ready, output, 1 bit: the ALU result is accepted this cycle.
REQ-010 The block SHALL have the port mem_valid, input, 1 bit: load data is pending.
REQ-011 The block SHALL have the port mem_rd, input, REG_ADDR_WIDTH bits: destination register of the load.
REQ-012 The block SHALL have the port mem_data, input, DATA_WIDTH bits: the load data.
REQ-013 The block SHALL have the port mem_ready, output, 1 bit: the load data is accepted this cycle.
REQ-014 The block SHALL have the port MemToReg, output, 1 bit: writeback mux select, 0 = ALU and 1 = memory.
REQ-015 The block SHALL have the port RegWrite, output, 1 bit: register-file write enable.
REQ-016 The block SHALL have the port wb_addr, output, REG_ADDR_WIDTH bits: register-file write address.
REQ-017 The block SHALL have the port wb_data, output, DATA_WIDTH bits: registered writeback data.

Function
REQ-018 A transfer SHALL occur on a source when its valid and ready are both 1 at a rising edge of clk.
REQ-019 A source SHALL hold its valid high, with stable rd and data, until the transfer occurs.
REQ-020 alu_ready and mem_ready SHALL be combinational from the valids and the internal state, and they SHALL never both be 1 in the same cycle.
REQ-021 The arbitration policy SHALL be:
- only one source valid: that source is granted;
- both valid and streak < MAX_STREAK: memory is granted;
- both valid and streak == MAX_STREAK: ALU is granted.
REQ-022 The streak counter SHALL be $clog2(MAX_STREAK+1) bits wide.
- It increments on a memory grant while alu_valid=1.
- It clears to 0 on any ALU grant or on any cycle with alu_valid=0.
- It saturates at MAX_STREAK and never wraps.
REQ-023 The output stage SHALL be a three-state FSM:
- IDLE: no write.
- WB_ALU: ALU write.
- WB_MEM: memory write.
REQ-024 The next state SHALL be WB_MEM on a memory grant, WB_ALU on an ALU grant, and IDLE otherwise; every transition is reachable from every state.
REQ-025 Latency SHALL be exactly one cycle: the edge that completes a transfer loads wb_addr, wb_data and MemToReg, and RegWrite=1 is asserted for exactly the following cycle.
REQ-026 Throughput SHALL be one writeback per cycle; back-to-back grants produce back-to-back RegWrite pulses with no bubble.
REQ-027 In the WB_ALU state MemToReg SHALL be 0, and in the WB_MEM state MemToReg SHALL be 1.
REQ-028 In the IDLE state RegWrite SHALL be 0, and MemToReg, wb_addr and wb_data SHALL hold their last values.
REQ-029 When both sources target the same register in the same cycle, the memory write SHALL be performed first and the ALU write in a later cycle, so the ALU value is final.
REQ-030 A transfer SHALL copy alu_data or mem_data into wb_data unmodified, with full DATA_WIDTH and no truncation or extension.

Reset
REQ-031 While rst_n=0, asynchronously:
- the state SHALL be IDLE, the streak SHALL be 0, and RegWrite, MemToReg, wb_addr and wb_data SHALL be 0;
- alu_ready and mem_ready SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard any pending write, and the aborted RegWrite pulse SHALL not appear after reset is released.
REQ-033 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 Reset scenario: rst_n=0 is applied mid-stream while RegWrite=1 -> RegWrite=0, wb_data=0 and both readies=0 immediately, and there is no write after release.
REQ-035 Single-ALU scenario: alu_valid=1, alu_rd=5, alu_data=16'h1234 are applied for one cycle -> alu_ready=1 in that cycle, and in the next cycle RegWrite=1, MemToReg=0, wb_addr=5, wb_data=16'h1234.
REQ-036 Single-memory scenario: mem_valid=1, mem_rd=2, mem_data=16'hBEEF are applied -> in the next cycle RegWrite=1, MemToReg=1, wb_addr=2, wb_data=16'hBEEF.
REQ-037 Collision scenario: both sources are valid with rd=3 (memory 16'h00AA, ALU 16'h0055) -> the memory write occurs first and the ALU write occurs in the next cycle, leaving final register value 16'h0055.
REQ-038 Starvation scenario: mem_valid=1 and alu_valid=1 are held continuously with MAX_STREAK=3 -> grants follow the repeating pattern M,M,M,A, and RegWrite stays 1 every cycle.
REQ-039 Idle-hold scenario: a grant is followed by no valids -> RegWrite=0 and wb_addr, wb_data and MemToReg stay unchanged.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: picks one of the ALU or load results per cycle for the register file.
// Loads win a collision, but after MAX_STREAK load grants in a row a waiting ALU result goes next.
module writeback_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int MAX_STREAK     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  output logic                      mem_ready,
  output logic                      MemToReg,
  output logic                      RegWrite,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]     wb_data
);

  localparam int SW = ($clog2(MAX_STREAK + 1) < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_STREAK);
  localparam logic [SW-1:0] ONE   = SW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB_ALU = 2'd1,
    WB_MEM = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [SW-1:0]               streak_q, streak_d;
  logic                        mem_gnt, alu_gnt;
  logic                        sel_q;
  logic [REG_ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]       data_q;

  // Readies are forced low while reset is held, so nothing can transfer then.
  always_comb begin
    mem_gnt  = 1'b0;
    alu_gnt  = 1'b0;
    if (rst_n) begin
      if (mem_valid && (!alu_valid || (streak_q < MAX_S))) begin
        mem_gnt = 1'b1;
      end else if (alu_valid) begin
        alu_gnt = 1'b1;
      end
    end

    streak_d = streak_q;
    if (!alu_valid || alu_gnt) begin
      streak_d = '0;
    end else if (mem_gnt && (streak_q < MAX_S)) begin
      streak_d = streak_q + ONE;
    end

    if (mem_gnt) begin
      state_d = WB_MEM;
    end else if (alu_gnt) begin
      state_d = WB_ALU;
    end else begin
      state_d = IDLE;
    end
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      case (state_d)
        WB_MEM: begin
          sel_q  <= 1'b1;
          addr_q <= mem_rd;
          data_q <= mem_data;
        end
        WB_ALU: begin
          sel_q  <= 1'b0;
          addr_q <= alu_rd;
          data_q <= alu_data;
        end
        default: begin
          sel_q  <= sel_q;
          addr_q <= addr_q;
          data_q <= data_q;
        end
      endcase
    end
  end

  assign RegWrite = (state_q != IDLE);
  assign MemToReg = sel_q;
  assign wb_addr  = addr_q;
  assign wb_data  = data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, single sources, collision, starvation, idle hold.
module tb_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic [2:0]  alu_rd, mem_rd;
  logic [15:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        MemToReg, RegWrite;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  int nvec = 0;
  int nerr = 0;

  writeback_arbiter #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3), .MAX_STREAK(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                       input logic mv, input logic [2:0] mr, input logic [15:0] md);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    tick();
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_MemToReg", MemToReg, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);

    // Single ALU result, granted on the first edge after release
    rst_n = 1'b1;
    drive(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 16'h0000);
    chk("alu_ready", alu_ready, 1);
    chk("alu_only_mem_ready", mem_ready, 0);
    tick();
    chk("alu_RegWrite", RegWrite, 1);
    chk("alu_MemToReg", MemToReg, 0);
    chk("alu_wb_addr", wb_addr, 5);
    chk("alu_wb_data", wb_data, 16'h1234);

    // Idle hold after ALU write
    drive(1'b0, 3'd7, 16'hFFFF, 1'b0, 3'd7, 16'hFFFF);
    tick();
    chk("idle1_RegWrite", RegWrite, 0);
    chk("idle1_MemToReg", MemToReg, 0);
    chk("idle1_wb_addr", wb_addr, 5);
    chk("idle1_wb_data", wb_data, 16'h1234);

    // Single load
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'hBEEF);
    chk("mem_ready", mem_ready, 1);
    chk("mem_only_alu_ready", alu_ready, 0);
    tick();
    chk("mem_RegWrite", RegWrite, 1);
    chk("mem_MemToReg", MemToReg, 1);
    chk("mem_wb_addr", wb_addr, 2);
    chk("mem_wb_data", wb_data, 16'hBEEF);

    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    tick();
    chk("idle2_RegWrite", RegWrite, 0);
    chk("idle2_MemToReg", MemToReg, 1);
    chk("idle2_wb_addr", wb_addr, 2);
    chk("idle2_wb_data", wb_data, 16'hBEEF);

    // Collision on r3: load first, ALU afterwards
    drive(1'b1, 3'd3, 16'h0055, 1'b1, 3'd3, 16'h00AA);
    chk("col_mem_ready", mem_ready, 1);
    chk("col_alu_ready", alu_ready, 0);
    tick();
    chk("col1_RegWrite", RegWrite, 1);
    chk("col1_MemToReg", MemToReg, 1);
    chk("col1_wb_data", wb_data, 16'h00AA);
    drive(1'b1, 3'd3, 16'h0055, 1'b0, 3'd0, 16'h0000);
    chk("col2_alu_ready", alu_ready, 1);
    tick();
    chk("col2_RegWrite", RegWrite, 1);
    chk("col2_MemToReg", MemToReg, 0);
    chk("col2_wb_addr", wb_addr, 3);
    chk("col2_wb_data", wb_data, 16'h0055);

    // Streak clears when the ALU stops requesting: M,M then load alone, then M,M,M,A
    drive(1'b1, 3'd6, 16'h5555, 1'b1, 3'd1, 16'hAAAA);
    chk("clr_m1", mem_ready, 1);
    tick();
    chk("clr_m2", mem_ready, 1);
    tick();
    drive(1'b0, 3'd6, 16'h5555, 1'b1, 3'd1, 16'hAAAA);
    chk("clr_solo", mem_ready, 1);
    tick();

    // Both held: grants repeat M,M,M,A with no bubble
    drive(1'b1, 3'd6, 16'h5555, 1'b1, 3'd1, 16'hAAAA);
    for (int i = 0; i < 8; i++) begin
      logic exp_m;
      exp_m = ((i % 4) != 3);
      chk($sformatf("starve%0d_mem_ready", i), mem_ready, exp_m);
      chk($sformatf("starve%0d_alu_ready", i), alu_ready, !exp_m);
      tick();
      chk($sformatf("starve%0d_RegWrite", i), RegWrite, 1);
      chk($sformatf("starve%0d_MemToReg", i), MemToReg, exp_m);
      chk($sformatf("starve%0d_wb_data", i), wb_data, exp_m ? 16'hAAAA : 16'h5555);
    end

    // Reset mid-stream while a write is showing
    chk("pre_rst_RegWrite", RegWrite, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_RegWrite", RegWrite, 0);
    chk("mid_rst_wb_data", wb_data, 0);
    chk("mid_rst_alu_ready", alu_ready, 0);
    chk("mid_rst_mem_ready", mem_ready, 0);
    tick();
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("post_rst_RegWrite", RegWrite, 0);
    chk("post_rst_wb_addr", wb_addr, 0);
    tick();
    chk("post_rst2_RegWrite", RegWrite, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
